// File: rtl/inverter.sv
// Bitwise inverter with a clocked monitor alongside it: registered inverse,
// per-bit edge pulses and a saturating switching-activity counter.
module inverter #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_toggle,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] inv_q, inv_d;
    logic [WIDTH-1:0] a_prev_q, a_prev_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff;

    // Primary gate path: independent of clk, rst and all monitor state.
    assign y = ~a;

    always_comb begin
        diff     = a ^ a_prev_q;
        inv_d    = ~a;
        a_prev_d = a;
        rise_d   = a & ~a_prev_q;
        fall_d   = ~a & a_prev_q;
        tog_d    = |diff;
        cnt_d    = cnt_q;
        // Clear beats increment; the counter saturates at all ones.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if ((|diff) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q    <= {WIDTH{1'b1}};
            a_prev_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            tog_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            inv_q    <= inv_d;
            a_prev_q <= a_prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            tog_q    <= tog_d;
            cnt_q    <= cnt_d;
        end
    end

    assign y_q        = inv_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_toggle = tog_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_inverter.sv
// Directed bench for inverter: a WIDTH=4 instance for the main checks and a
// WIDTH=1/CNT_W=2 instance for the standalone-gate and saturation cases.
module tb_inverter;

    logic        clk = 1'b0;
    bit          clk_run = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  a = 4'h0;
    logic        clr_cnt = 1'b0;
    logic [3:0]  y, y_q, rise, fall;
    logic        any_toggle;
    logic [15:0] toggle_cnt;

    logic        a_s = 1'b0;
    logic        clr_s = 1'b0;
    logic        y_s, yq_s, rise_s, fall_s, tog_s;
    logic [1:0]  cnt_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 if (clk_run) clk = ~clk;

    inverter #(.WIDTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .a(a), .y(y), .y_q(y_q), .rise(rise), .fall(fall),
        .any_toggle(any_toggle), .clr_cnt(clr_cnt), .toggle_cnt(toggle_cnt)
    );

    inverter #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(a_s), .y(y_s), .y_q(yq_s), .rise(rise_s), .fall(fall_s),
        .any_toggle(tog_s), .clr_cnt(clr_s), .toggle_cnt(cnt_s)
    );

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb();
        logic [2:0] pat;
        pat = 3'b010;
        for (int i = 0; i < 3; i++) begin
            a_s = pat[i];
            a   = pat[i] ? 4'h6 : 4'h9;
            #1;
            n_vec++;
            if (y_s !== ~pat[i]) begin
                n_err++;
                $display("FAIL comb_w1[%0d]: y=%b expected %b", i, y_s, ~pat[i]);
            end
            n_vec++;
            if (y !== (pat[i] ? 4'h9 : 4'h6)) begin
                n_err++;
                $display("FAIL comb_w4[%0d]: y=%h expected %h", i, y, pat[i] ? 4'h9 : 4'h6);
            end
            #9;
        end
    endtask

    task automatic test_reset();
        clk_run = 1'b1;
        a = 4'h3;
        edge_step();
        edge_step();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({y_q, rise, fall, any_toggle, toggle_cnt} !== {4'hF, 4'h0, 4'h0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_async: y_q=%h rise=%h fall=%h tog=%b cnt=%0d expected F 0 0 0 0",
                     y_q, rise, fall, any_toggle, toggle_cnt);
        end
        n_vec++;
        if ({yq_s, rise_s, fall_s, tog_s, cnt_s} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_async_w1: got %b expected 10000", {yq_s, rise_s, fall_s, tog_s, cnt_s});
        end
        a = 4'hC;
        #1;
        n_vec++;
        if (y !== 4'h3 || y_q !== 4'hF) begin
            n_err++;
            $display("FAIL reset_y_follows: y=%h y_q=%h expected 3 F", y, y_q);
        end
        edge_step();
        n_vec++;
        if ({y_q, rise, fall, any_toggle, toggle_cnt} !== {4'hF, 4'h0, 4'h0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_held: y_q=%h rise=%h fall=%h tog=%b cnt=%0d expected F 0 0 0 0",
                     y_q, rise, fall, any_toggle, toggle_cnt);
        end
        @(negedge clk);
        a = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_edges();
        logic [3:0]  va [4] = '{4'h0, 4'hA, 4'hA, 4'h5};
        logic [3:0]  eyq[4] = '{4'hF, 4'h5, 4'h5, 4'hA};
        logic [3:0]  er [4] = '{4'h0, 4'hA, 4'h0, 4'h5};
        logic [3:0]  ef [4] = '{4'h0, 4'h0, 4'h0, 4'hA};
        logic        et [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] ec [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
        for (int i = 0; i < 4; i++) begin
            a = va[i];
            edge_step();
            n_vec++;
            if ({y_q, rise, fall, any_toggle, toggle_cnt} !== {eyq[i], er[i], ef[i], et[i], ec[i]}) begin
                n_err++;
                $display("FAIL edges[%0d]: y_q=%h rise=%h fall=%h tog=%b cnt=%0d expected %h %h %h %b %0d",
                         i, y_q, rise, fall, any_toggle, toggle_cnt, eyq[i], er[i], ef[i], et[i], ec[i]);
            end
        end
    endtask

    task automatic test_counter();
        clr_cnt = 1'b1;
        edge_step();
        clr_cnt = 1'b0;
        n_vec++;
        if (toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL cnt_clear: cnt=%0d expected 0", toggle_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            a = ~a;
            edge_step();
            n_vec++;
            if (toggle_cnt !== 16'(i + 1) || any_toggle !== 1'b1) begin
                n_err++;
                $display("FAIL cnt_inc[%0d]: cnt=%0d tog=%b expected %0d 1", i, toggle_cnt, any_toggle, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            n_vec++;
            if (toggle_cnt !== 16'd5 || any_toggle !== 1'b0) begin
                n_err++;
                $display("FAIL cnt_hold[%0d]: cnt=%0d tog=%b expected 5 0", i, toggle_cnt, any_toggle);
            end
        end
        clr_cnt = 1'b1;
        a = 4'h5;
        edge_step();
        clr_cnt = 1'b0;
        n_vec++;
        if (toggle_cnt !== 16'd0 || any_toggle !== 1'b1 || rise !== 4'h5 || fall !== 4'hA) begin
            n_err++;
            $display("FAIL cnt_clear_wins: cnt=%0d tog=%b rise=%h fall=%h expected 0 1 5 A",
                     toggle_cnt, any_toggle, rise, fall);
        end
        edge_step();
        n_vec++;
        if (toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL cnt_after_clear: cnt=%0d expected 0", toggle_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c;
        for (int i = 0; i < 6; i++) begin
            a_s = ~a_s;
            edge_step();
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_vec++;
            if (cnt_s !== exp_c || tog_s !== 1'b1 || rise_s === fall_s) begin
                n_err++;
                $display("FAIL sat[%0d]: cnt=%0d tog=%b rise=%b fall=%b expected cnt %0d tog 1",
                         i, cnt_s, tog_s, rise_s, fall_s, exp_c);
            end
        end
    endtask

    task automatic test_glitch();
        a = 4'h0;
        edge_step();
        n_vec++;
        if (toggle_cnt !== 16'd1 || fall !== 4'h5 || rise !== 4'h0) begin
            n_err++;
            $display("FAIL glitch_setup: cnt=%0d fall=%h rise=%h expected 1 5 0", toggle_cnt, fall, rise);
        end
        #1 a = 4'h1;
        #1;
        n_vec++;
        if (y !== 4'hE) begin
            n_err++;
            $display("FAIL glitch_y_low: y=%h expected E", y);
        end
        #1 a = 4'h0;
        #1;
        n_vec++;
        if (y !== 4'hF) begin
            n_err++;
            $display("FAIL glitch_y_back: y=%h expected F", y);
        end
        edge_step();
        n_vec++;
        if ({rise, fall, any_toggle, toggle_cnt} !== {4'h0, 4'h0, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL glitch_invisible: rise=%h fall=%h tog=%b cnt=%0d expected 0 0 0 1",
                     rise, fall, any_toggle, toggle_cnt);
        end
    endtask

    task automatic test_reset_midop();
        a = 4'hF;
        edge_step();
        n_vec++;
        if (toggle_cnt !== 16'd2 || y_q !== 4'h0 || rise !== 4'hF) begin
            n_err++;
            $display("FAIL midop_pre: cnt=%0d y_q=%h rise=%h expected 2 0 F", toggle_cnt, y_q, rise);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({y, y_q, rise, fall, any_toggle, toggle_cnt} !== {4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL midop_reset: y=%h y_q=%h rise=%h fall=%h tog=%b cnt=%0d expected 0 F 0 0 0 0",
                     y, y_q, rise, fall, any_toggle, toggle_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        n_vec++;
        if (rise !== 4'hF || toggle_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL midop_after: rise=%h cnt=%0d expected F 1", rise, toggle_cnt);
        end
    endtask

    initial begin
        test_comb();
        test_reset();
        test_edges();
        test_counter();
        test_saturation();
        test_glitch();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inverter.md
Name: inverter

Overview:
- Basic CMOS-style logic inverter for the gate library, with optional registered observation outputs.
- The primary path y = ~a is purely combinational. It must work with the clock stopped and reset in any state, so it can be exercised standalone.
- A small clocked monitor alongside it provides a registered inverse, per-bit edge pulses and a saturating switching-activity counter.
- The monitor is used for switching-activity (dynamic-power) characterisation of gate-level test structures.

Parameters:
- WIDTH, 1, number of independent inverter bits (≥1).
- CNT_W, 16, width of the toggle counter (≥2).

Ports:
- clk  input  1  monitor clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset of all monitor state; does not affect y.
- a  input  WIDTH  data input.
- y  output  WIDTH  combinational inverse of a.
- y_q  output  WIDTH  registered inverse of a.
- rise  output  WIDTH  per-bit 1-cycle pulse: bit went 0→1 between consecutive samples.
- fall  output  WIDTH  per-bit 1-cycle pulse: bit went 1→0 between consecutive samples.
- any_toggle  output  1  registered OR of rise|fall.
- clr_cnt  input  1  synchronous clear of toggle_cnt.
- toggle_cnt  output  CNT_W  saturating count of cycles with any_toggle condition.

Behaviour:
- Combinational path:
  - y = ~a bitwise, at all times.
  - Zero clock latency; no dependency on clk, rst or any internal state.
  - X/Z on an input bit propagates as X on the corresponding y bit in simulation.
- Reset (rst=1, asynchronous, immediate):
  - y_q = all ones.
  - a_prev (internal last-sample register) = 0.
  - rise = fall = 0.
  - any_toggle = 0.
  - toggle_cnt = 0.
  - While rst is held, all monitor state stays at these values.
  - Deassertion is synchronised by design convention (released between clock edges).
- Each rising clk edge with rst=0:
  - y_q <= ~a (1-cycle latency).
  - a_prev <= a.
  - rise <= a & ~a_prev.
  - fall <= ~a & a_prev.
  - any_toggle <= |(a ^ a_prev).
- Counter, evaluated on the same edge:
  - If clr_cnt=1: toggle_cnt <= 0. Clear has priority over increment when both occur in the same cycle.
  - Else if |(a ^ a_prev) and toggle_cnt != max: toggle_cnt <= toggle_cnt+1.
  - At max (all ones), toggle_cnt holds; it never wraps.
- Edge-detection semantics:
  - Edges are measured against a_prev. The first sample after reset compares against 0, so a=1 at the first edge yields a rise pulse.
  - Input changes narrower than a clock period that return before the next edge are invisible to the monitor but are still reflected on y.
  - rise and fall for the same bit are never both 1.
- Reset mid-operation: counter, pulses and y_q return immediately to their reset values; y is unaffected.

Test Plan:
1. Combinational only, clk held 0, rst held 0 (WIDTH=1): a=0 for 10 ns → y=1; a=1 for 10 ns → y=0; a=0 for 10 ns → y=1. Check y within 1 ns of each change.
2. Reset: with clk running, assert rst=1 asynchronously mid-cycle → y_q=1, rise=fall=0, any_toggle=0, toggle_cnt=0 before the next edge. Toggle a during reset → y still follows ~a.
3. Registered path and edges (WIDTH=4): sequence 4'h0, 4'hA, 4'hA, 4'h5 on successive edges.
   - After the edge sampling 4'hA: y_q=4'h5, rise=4'hA, fall=0, any_toggle=1.
   - Next edge (4'hA again): rise=fall=0, any_toggle=0.
   - Next edge (4'h5): rise=4'h5, fall=4'hA.
4. Counter: toggle a every cycle for 5 cycles → toggle_cnt=5. Hold a steady for 3 cycles → stays 5. Pulse clr_cnt while a toggles → toggle_cnt=0 (clear wins).
5. Saturation (CNT_W=2): toggle a for 6 cycles → toggle_cnt reaches 3 and holds at 3.
6. Glitch: with clk period 10 ns, pulse a 0→1→0 for 2 ns between edges → y shows a 2 ns low pulse; rise, fall and toggle_cnt are unchanged.
